// File: rtl/pwm_multi_ctrl_if.sv
// pwm_multi_ctrl_if: control inputs and PWM/duty outputs of pwm_multi_ctrl, grouped for one port.
// Latency: none, this is wiring only.
// Backpressure: none; the slave samples every input on each clk.
// Ports: master drives en, mode, inc, dec, wr_en, wr_ch, wr_duty and observes
//        pwm_out, duty_flat, period_tick; slave is the mirror image.
interface pwm_multi_ctrl_if #(
  parameter int N_CH = 2,
  parameter int CW   = 4,
  parameter int WCH  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                 en;
  logic                 mode;
  logic [N_CH-1:0]      inc;
  logic [N_CH-1:0]      dec;
  logic                 wr_en;
  logic [WCH-1:0]       wr_ch;
  logic [CW-1:0]        wr_duty;
  logic [N_CH-1:0]      pwm_out;
  logic [N_CH*CW-1:0]   duty_flat;
  logic                 period_tick;

  modport master (
    output en, mode, inc, dec, wr_en, wr_ch, wr_duty,
    input  pwm_out, duty_flat, period_tick
  );

  modport slave (
    input  en, mode, inc, dec, wr_en, wr_ch, wr_duty,
    output pwm_out, duty_flat, period_tick
  );
endinterface

// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl: N-channel PWM, shared counter, debounced per-channel duty buttons, direct duty load.
// Latency: pwm_out is one clk behind the counter; duty_flat shows an update one clk later.
// Backpressure: none; every write or press is accepted in the cycle it is seen.
// Ports: clk, rst (synchronous, active-high), bus (slave modport of pwm_multi_ctrl_if).
module pwm_multi_ctrl #(
  parameter int N_CH      = 2,
  parameter int CW        = 4,
  parameter int PERIOD    = 10,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = 4
) (
  input  logic            clk,
  input  logic            rst,
  pwm_multi_ctrl_if.slave bus
);
  localparam int              DW       = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_DIV - 1);
  localparam logic [CW-1:0]   PER      = CW'(PERIOD);
  localparam logic [CW-1:0]   PER_M1   = CW'(PERIOD - 1);
  localparam logic [CW-1:0]   D_INIT   = CW'(DUTY_INIT);
  localparam logic [CW:0]     STP_X    = (CW+1)'(STEP);
  localparam logic [CW:0]     PER_X    = (CW+1)'(PERIOD);

  // ---------------- debounce: slow sampler shared by all buttons ----------------
  logic [DW-1:0]   deb_cnt;
  logic            tick;
  logic [N_CH-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
  logic [N_CH-1:0] inc_p, dec_p;

  assign tick = (deb_cnt == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      inc_s1  <= '0;
      inc_s2  <= '0;
      dec_s1  <= '0;
      dec_s2  <= '0;
    end else begin
      deb_cnt <= tick ? '0 : deb_cnt + DW'(1);
      if (tick) begin
        inc_s1 <= bus.inc;
        inc_s2 <= inc_s1;
        dec_s1 <= bus.dec;
        dec_s2 <= dec_s1;
      end
    end
  end

  // Rising edge of the sampled level, qualified by tick so it lasts exactly one clk.
  assign inc_p = inc_s1 & ~inc_s2 & {N_CH{tick}};
  assign dec_p = dec_s1 & ~dec_s2 & {N_CH{tick}};

  // ---------------- shadow duty update ----------------
  logic [N_CH-1:0][CW-1:0] duty_sh, duty_nxt, duty_act;

  // Arithmetic is done one bit wider so the saturation compare never sees a wrapped sum.
  always_comb begin
    duty_nxt = duty_sh;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.wr_en && (int'(bus.wr_ch) == i)) begin
        duty_nxt[i] = (bus.wr_duty > PER) ? PER : bus.wr_duty;
      end else if (inc_p[i] && !dec_p[i]) begin
        duty_nxt[i] = (({1'b0, duty_sh[i]} + STP_X) > PER_X) ? PER
                      : CW'({1'b0, duty_sh[i]} + STP_X);
      end else if (dec_p[i] && !inc_p[i]) begin
        duty_nxt[i] = ({1'b0, duty_sh[i]} < STP_X) ? '0
                      : CW'({1'b0, duty_sh[i]} - STP_X);
      end
    end
  end

  // ---------------- shared counter, active-duty transfer, outputs ----------------
  logic [CW-1:0]   cnt;
  logic            dir_dn;
  logic            mode_act;
  logic            boundary;
  logic [N_CH-1:0] pwm_q;

  // Last clk of a period: top of the ramp in edge mode, second visit of 0 in centre mode.
  assign boundary = mode_act ? ((cnt == '0) && dir_dn) : (cnt == PER_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dir_dn   <= 1'b0;
      mode_act <= 1'b0;
      duty_sh  <= {N_CH{D_INIT}};
      duty_act <= {N_CH{D_INIT}};
      pwm_q    <= '0;
    end else begin
      duty_sh <= duty_nxt;
      for (int i = 0; i < N_CH; i++) begin
        pwm_q[i] <= bus.en && (cnt < duty_act[i]);
      end
      // Active duty and mode only change between periods, so no output glitches mid-period.
      // A fresh period always starts at cnt=0 counting up, which also covers a mode change.
      if (!bus.en || boundary) begin
        cnt      <= '0;
        dir_dn   <= 1'b0;
        mode_act <= bus.mode;
        duty_act <= duty_sh;
      end else if (!mode_act) begin
        cnt <= cnt + CW'(1);
      end else if (!dir_dn) begin
        // Top endpoint is held one extra clk while the direction flips.
        if (cnt == PER_M1) dir_dn <= 1'b1;
        else               cnt    <= cnt + CW'(1);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.duty_flat   = duty_sh;
  assign bus.period_tick = bus.en & boundary;
endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// tb_pwm_multi_ctrl: randomized and directed stimulus for pwm_multi_ctrl against a period-position model.
// Latency: model predicts registered outputs one clk after the inputs that cause them.
// Backpressure: none; the bench drives every cycle.
module tb_pwm_multi_ctrl;
  localparam int N_CH  = 2;
  localparam int CW    = 4;
  localparam int P     = 10;
  localparam int STEP  = 1;
  localparam int DINIT = 5;
  localparam int DEB   = 4;
  localparam int OW    = 1 + N_CH + N_CH * CW;

  logic clk;
  logic rst;

  pwm_multi_ctrl_if #(.N_CH(N_CH), .CW(CW)) bus ();

  pwm_multi_ctrl #(
    .N_CH(N_CH), .CW(CW), .PERIOD(P), .STEP(STEP), .DUTY_INIT(DINIT), .DEB_DIV(DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [OW-1:0] obs;
  assign obs = {bus.period_tick, bus.pwm_out, bus.duty_flat};

  // ---------------- reference model ----------------
  // pos is the position inside the current period (0..len-1); the output level
  // follows from the ramp value that position maps to.
  int dph;
  int pos;
  bit mact;
  int sh  [N_CH];
  int act [N_CH];
  bit pwm [N_CH];
  bit si_new [N_CH], si_old [N_CH], sd_new [N_CH], sd_old [N_CH];

  function automatic int lenp(bit m);
    return m ? 2 * P : P;
  endfunction

  function automatic int ramp(int p, bit m);
    if (!m || p < P) return p;
    return 2 * P - 1 - p;
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    logic [OW-1:0] v;
    v = '0;
    v[OW-1] = bus.en && (pos == lenp(mact) - 1);
    for (int i = 0; i < N_CH; i++) begin
      v[N_CH*CW + i]  = pwm[i];
      v[i*CW +: CW]   = CW'(sh[i]);
    end
    return v;
  endfunction

  task automatic step();
    bit tk, ip, dp;
    int nsh [N_CH];
    if (rst) begin
      dph = 0; pos = 0; mact = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        si_new[i] = 0; si_old[i] = 0; sd_new[i] = 0; sd_old[i] = 0;
        sh[i] = DINIT; act[i] = DINIT; pwm[i] = 0;
      end
    end else begin
      tk = (dph == DEB - 1);
      for (int i = 0; i < N_CH; i++) begin
        ip = tk && si_new[i] && !si_old[i];
        dp = tk && sd_new[i] && !sd_old[i];
        nsh[i] = sh[i];
        if (bus.wr_en && int'(bus.wr_ch) == i) nsh[i] = (int'(bus.wr_duty) > P) ? P : int'(bus.wr_duty);
        else if (ip && !dp)                     nsh[i] = (sh[i] + STEP > P) ? P : sh[i] + STEP;
        else if (dp && !ip)                     nsh[i] = (sh[i] < STEP) ? 0 : sh[i] - STEP;
        pwm[i] = bus.en && (ramp(pos, mact) < act[i]);
        if (tk) begin
          si_old[i] = si_new[i]; si_new[i] = bus.inc[i];
          sd_old[i] = sd_new[i]; sd_new[i] = bus.dec[i];
        end
      end
      dph = (dph + 1) % DEB;
      if (!bus.en || pos == lenp(mact) - 1) begin
        pos = 0;
        mact = bus.mode;
        for (int i = 0; i < N_CH; i++) act[i] = sh[i];
      end else begin
        pos++;
      end
      for (int i = 0; i < N_CH; i++) sh[i] = nsh[i];
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.mode = 1'b0; bus.inc = '1; bus.dec = '0;
    bus.wr_en = 1'b1; bus.wr_ch = '0; bus.wr_duty = 4'd9;
    step(); step();
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
    else n_pass++;
    n_checks++;
    if (obs !== 11'h055) $display("FAIL reset_values cyc=%0d got=%h want=%h", cyc, obs, 11'h055);
    else n_pass++;
    rst = 1'b0; bus.inc = '0; bus.wr_en = 1'b0;
  endtask

  task automatic test_edge_default();
    int highs, ticks;
    highs = 0; ticks = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      highs += int'(bus.pwm_out[0]);
      ticks += int'(bus.period_tick);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL edge_wave cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (highs != 20) $display("FAIL edge_high_count got=%0d want=20", highs);
    else n_pass++;
    n_checks++;
    if (ticks != 4) $display("FAIL edge_tick_count got=%0d want=4", ticks);
    else n_pass++;
  endtask

  task automatic test_press_debounce();
    while (dph != DEB - 1) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL press_align cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
    // One-clk glitch between ticks, then a clean hold of 3 debounce intervals.
    for (int k = 0; k < 40; k++) begin
      bus.inc[0] = (k == 1) || (k >= 3 && k < 15);
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL press_wave cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (bus.duty_flat !== 8'h56) $display("FAIL press_duty got=%h want=%h", bus.duty_flat, 8'h56);
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL press_after cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_write();
    int wv [2];
    int ev [2];
    int highs;
    wv = '{15, 0};
    ev = '{1, 0};
    for (int w = 0; w < 2; w++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 1'b1; bus.wr_duty = 4'(wv[w]);
      step();
      bus.wr_en = 1'b0;
      highs = 0;
      for (int k = 0; k < 30; k++) begin
        step();
        if (k >= 20) highs += int'(bus.pwm_out[1]);
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL write_wave cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
        else n_pass++;
      end
      n_checks++;
      if (int'(bus.duty_flat[7:4]) != wv[w] - 5 * ev[w])
        $display("FAIL write_clamp got=%0d want=%0d", bus.duty_flat[7:4], wv[w] - 5 * ev[w]);
      else n_pass++;
      n_checks++;
      if (highs != 10 * ev[w]) $display("FAIL write_const got=%0d want=%0d", highs, 10 * ev[w]);
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    int wval [4];
    int want [4];
    wval = '{10, 0, 4, 9};
    want = '{10, 0, 4, 8};
    for (int op = 0; op < 4; op++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_duty = 4'(wval[op]);
      step();
      bus.wr_en = 1'b0;
      for (int k = 0; k < 24; k++) begin
        bus.inc[0] = (k < 12) && (op == 0 || op == 2);
        bus.dec[0] = (k < 12) && (op != 0);
        step();
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL clamp_wave cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
        else n_pass++;
      end
      n_checks++;
      if (int'(bus.duty_flat[3:0]) != want[op])
        $display("FAIL clamp_op%0d got=%0d want=%0d", op, bus.duty_flat[3:0], want[op]);
      else n_pass++;
    end
  endtask

  task automatic test_centre();
    int highs;
    bus.mode = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 1'(c); bus.wr_duty = 4'd3;
      step();
    end
    bus.wr_en = 1'b0;
    highs = 0;
    for (int k = 0; k < 70; k++) begin
      step();
      if (k >= 30) highs += int'(bus.pwm_out[0]);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL centre_wave cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (highs != 12) $display("FAIL centre_high_count got=%0d want=12", highs);
    else n_pass++;
    bus.mode = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL centre_to_edge cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid_and_en();
    int highs, ticks;
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_duty = 4'd9; bus.inc = '1;
    step();
    n_checks++;
    if (obs !== 11'h055) $display("FAIL rst_mid got=%h want=%h", obs, 11'h055);
    else n_pass++;
    rst = 1'b0; bus.wr_en = 1'b0; bus.inc = '0; bus.en = 1'b0;
    highs = 0; ticks = 0;
    for (int k = 0; k < 25; k++) begin
      bus.wr_en = (k == 5); bus.wr_ch = 1'b1; bus.wr_duty = 4'd7;
      step();
      highs += int'(bus.pwm_out[0]) + int'(bus.pwm_out[1]);
      ticks += int'(bus.period_tick);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL en_off_wave cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (highs + ticks != 0) $display("FAIL en_off_quiet got=%0d want=0", highs + ticks);
    else n_pass++;
    bus.wr_en = 1'b0; bus.en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL en_on_wave cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (bus.en ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0)) bus.en = ~bus.en;
      if ($urandom_range(0, 59) == 0) bus.mode = ~bus.mode;
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 9) == 0) bus.inc[i] = ~bus.inc[i];
        if ($urandom_range(0, 9) == 0) bus.dec[i] = ~bus.dec[i];
      end
      bus.wr_en   = ($urandom_range(0, 15) == 0);
      bus.wr_ch   = 1'($urandom_range(0, 1));
      bus.wr_duty = 4'($urandom_range(0, 15));
      step();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_edge_default();
    test_press_debounce();
    test_write();
    test_clamp();
    test_centre();
    test_rst_mid_and_en();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
